tff_counter: RTL and testbench
==============================

# tff_counter

Parametrised WIDTH-bit register built from per-bit toggle cells that generalises the single T flip-flop into a multi-mode block: per-bit toggle, synchronous up/down count, parallel load and hold. Counting can wrap or saturate, with a terminal-count indication and a sticky overflow flag. It is the general-purpose counter/toggle register for the lab designs and replaces ad-hoc chains of single T flip-flops.

## Interface

Parameters:
- WIDTH, 4: number of bits in q; legal range 1–32.
- RESET_VAL, 0: value of q while reset is high; must fit in WIDTH bits.
- SATURATE, 0: 0 means wrap at the ends of the range; 1 means hold at the ends of the range.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- en, input, 1: mode enable; when low, mode is ignored and q holds.
- mode, input, 2: 00 HOLD, 01 TOGGLE, 10 UP, 11 DOWN.
- t, input, WIDTH: per-bit toggle vector; used only in TOGGLE mode.
- load, input, 1: synchronous parallel load; highest priority after reset.
- d, input, WIDTH: load data.
- clr_ovf, input, 1: synchronous clear of ovf.
- q, output, WIDTH: register value.
- tc, output, 1: terminal count; combinational.
- ovf, output, 1: sticky overflow/underflow flag; registered.

## Operation

- Next-state priority, highest first:
  1. reset: q = RESET_VAL.
  2. load: q ← d. Independent of en; no effect on ovf.
  3. en = 0: q holds.
  4. HOLD: q holds.
  5. TOGGLE: q ← q ^ t. Bit i flips iff t[i] = 1; tc is never asserted in this mode.
  6. UP: q ← q + 1, modulo 2^WIDTH.
  7. DOWN: q ← q − 1, modulo 2^WIDTH.
- Arithmetic is unsigned, WIDTH bits, with no carry-out port.
- Every mode is expressed as a per-bit toggle-enable vector fed to the cells:
  - UP: bit i toggles iff all lower bits are 1.
  - DOWN: bit i toggles iff all lower bits are 0.
  - TOGGLE: the toggle vector is t.
  - Load is applied as a per-cell synchronous override.
- tc = en & ~load & ((mode == UP & q == all-ones) | (mode == DOWN & q == 0)).
- Boundary behaviour when tc = 1 at a rising edge:
  - SATURATE = 0: q wraps (all-ones → 0 for UP, 0 → all-ones for DOWN).
  - SATURATE = 1: q holds its value.
- ovf:
  - Set on any rising edge where tc = 1.
  - Cleared on an edge where clr_ovf = 1 and tc = 0.
  - When set and clear coincide, set wins.
  - Holds otherwise.
- Reset asserted mid-operation forces q = RESET_VAL and ovf = 0 immediately, without waiting for clk. Normal operation resumes on the first rising edge after reset deasserts.

## Timing

- q and ovf: one-cycle latency from inputs sampled at the rising edge.
- tc: combinational from q, en, mode and load in the same cycle. A consumer samples tc on the same edge at which the wrap or saturation takes effect.
- Reset values: q = RESET_VAL and ovf = 0. tc follows from q = RESET_VAL and the current inputs; it is 0 unless en = 1, load = 0 and the mode/value tc condition holds.
- Changing mode between edges is legal. The mode value present at the rising edge decides the update.
- d and t are don't-care when not selected.

## Structure

- Shared header tff_defs.vh holds:
  - The mode constants MODE_HOLD, MODE_TOGGLE, MODE_UP, MODE_DOWN.
  - The mode field width, 2.
- Sub-module tff_cell: one T flip-flop with async active-high reset.
  - Ports: clk, reset, rst_val, tog, ld, ld_val, q.
  - Instantiated WIDTH times by a generate loop.
- Top level contains:
  - The toggle-enable generation: the prefix-AND chains for UP and DOWN, and the mux selecting among UP, DOWN, TOGGLE and hold.
  - The saturation gate.
  - The tc logic.
  - The ovf register.

## Test plan

All scenarios use WIDTH = 4 and RESET_VAL = 0 unless stated.

- Async reset: pulse reset between clock edges while q = 9 → q = 0 and ovf = 0 immediately, before the next edge. With RESET_VAL = 5, q = 5.
- UP wrap (SATURATE = 0): load 13, then en = 1 with mode UP for 4 edges → q = 14, 15, 0, 1. tc = 1 only while q = 15. ovf = 1 from the edge at which q becomes 0.
- DOWN saturate (SATURATE = 1): load 2, then DOWN for 4 edges → q = 1, 0, 0, 0. tc = 1 while q = 0. ovf sets on the first edge with q = 0 and tc = 1.
- TOGGLE: start at q = 0; t = 1010 for one edge → q = 1010; t = 0110 for one edge → q = 1100. tc stays 0 throughout.
- Priority:
  - load = 1, d = 7, en = 1, mode UP, q = 15 → q = 7, tc = 0, ovf unchanged.
  - en = 0 with mode UP → q holds.
- ovf set/clear race: q = 15 with mode UP and clr_ovf = 1 in the same cycle → ovf stays 1. On the next cycle, clr_ovf = 1 with tc = 0 → ovf = 0.

Source files
------------

// File: rtl/tff_counter_pkg.sv
// Shared definitions for the toggle-cell counter: the mode encoding and its field width.
package tff_counter_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_UP     = 2'b10,
        MODE_DOWN   = 2'b11
    } mode_e;

endpackage

// File: rtl/tff_counter_cell.sv
// One T flip-flop with a synchronous parallel-load override and async active-high reset.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic tog,
    input  logic ld,
    input  logic ld_val,
    output logic q
);

    // NOTE: sequential state is written with <= so every cell samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= rst_val;
        end else if (ld) begin
            q <= ld_val;
        end else if (tog) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_counter.sv
// WIDTH-bit toggle/up/down/load register built from tff_cell instances, with
// optional saturation, combinational terminal count and a sticky overflow flag.
module tff_counter
    import tff_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0,
    parameter int SATURATE  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  t,
    input  logic              load,
    input  logic [WIDTH-1:0]  d,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic              ovf
);

    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    mode_e            mode_sel;
    logic [WIDTH-1:0] up_tog;
    logic [WIDTH-1:0] dn_tog;
    logic [WIDTH-1:0] tog_en;
    logic             all_ones;
    logic             all_zero;
    logic             ovf_q;
    logic             ovf_d;

    assign mode_sel = mode_e'(mode);

    // Prefix-AND chains: bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        up_tog[0] = 1'b1;
        dn_tog[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_tog[i] = up_tog[i-1] & q[i-1];
            dn_tog[i] = dn_tog[i-1] & ~q[i-1];
        end
    end

    assign all_ones = up_tog[WIDTH-1] & q[WIDTH-1];
    assign all_zero = dn_tog[WIDTH-1] & ~q[WIDTH-1];

    assign tc = en & ~load & (((mode_sel == MODE_UP)   & all_ones) |
                              ((mode_sel == MODE_DOWN) & all_zero));

    // NOTE: assigning the default first keeps this block free of inferred latches.
    always_comb begin
        tog_en = '0;
        if (en) begin
            case (mode_sel)
                MODE_TOGGLE: tog_en = t;
                MODE_UP:     tog_en = up_tog;
                MODE_DOWN:   tog_en = dn_tog;
                default:     tog_en = '0;
            endcase
        end
        if ((SATURATE != 0) && tc) begin
            tog_en = '0;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RST_V[i]),
            .tog     (tog_en[i]),
            .ld      (load),
            .ld_val  (d[i]),
            .q       (q[i])
        );
    end

    // Set beats clear when both occur on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (tc) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_tff_counter.sv
// Bench for tff_counter: three instances (wrap, saturate, RESET_VAL=5) share stimulus
// and are compared with directed constants and an arithmetic reference model.
module tb_tff_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [3:0] t;
    logic       load;
    logic [3:0] d;
    logic       clr_ovf;

    logic [3:0] dq   [3];
    logic       dtc  [3];
    logic       dovf [3];

    logic [3:0] mq   [3];
    logic       movf [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(4), .RESET_VAL(0), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t), .load(load), .d(d),
        .clr_ovf(clr_ovf), .q(dq[0]), .tc(dtc[0]), .ovf(dovf[0]));

    tff_counter #(.WIDTH(4), .RESET_VAL(0), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t), .load(load), .d(d),
        .clr_ovf(clr_ovf), .q(dq[1]), .tc(dtc[1]), .ovf(dovf[1]));

    tff_counter #(.WIDTH(4), .RESET_VAL(5), .SATURATE(0)) dut_rv5 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t), .load(load), .d(d),
        .clr_ovf(clr_ovf), .q(dq[2]), .tc(dtc[2]), .ovf(dovf[2]));

    function automatic int rv_of(int k);
        return (k == 2) ? 5 : 0;
    endfunction

    function automatic bit sat_of(int k);
        return (k == 1);
    endfunction

    // Terminal count from the mode rules: at the top of the range going up, bottom going down.
    function automatic bit model_tc(logic [3:0] qv);
        if (!en || load) return 1'b0;
        if (mode == 2'b10 && qv == 4'd15) return 1'b1;
        if (mode == 2'b11 && qv == 4'd0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                mq[k]   = 4'(rv_of(k));
                movf[k] = 1'b0;
            end else begin
                bit tcv;
                int nxt;
                tcv = model_tc(mq[k]);
                nxt = int'(mq[k]);
                if (load)                      nxt = int'(d);
                else if (!en)                  nxt = int'(mq[k]);
                else if (mode == 2'b01)        nxt = int'(mq[k] ^ t);
                else if (tcv && sat_of(k))     nxt = int'(mq[k]);
                else if (mode == 2'b10)        nxt = (int'(mq[k]) + 1) % 16;
                else if (mode == 2'b11)        nxt = (int'(mq[k]) + 15) % 16;
                mq[k] = 4'(nxt);
                if (tcv)          movf[k] = 1'b1;
                else if (clr_ovf) movf[k] = 1'b0;
            end
        end
    end

    task automatic set_in(input logic e, input logic [1:0] m, input logic [3:0] tv,
                          input logic l, input logic [3:0] dv, input logic c);
        en = e; mode = m; t = tv; load = l; d = dv; clr_ovf = c;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_in(1'b0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0);
        reset = 1'b1;
        #3;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dq[k] !== 4'(rv_of(k)) || dovf[k] !== 1'b0 || dtc[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d: q=%0d ovf=%b tc=%b, required q=%0d ovf=0 tc=0",
                         k, dq[k], dovf[k], dtc[k], rv_of(k));
            end
        end
        @(negedge clk);
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_q   [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
        logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        set_in(1'b0, 2'b00, 4'd0, 1'b1, 4'd13, 1'b0);
        cycle();
        set_in(1'b1, 2'b10, 4'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (dtc[0] !== exp_tc[i]) begin
                n_fail++;
                $display("FAIL up_wrap tc step %0d: got %b, required %b", i, dtc[0], exp_tc[i]);
            end
            cycle();
            n_checks++;
            if (dq[0] !== exp_q[i] || dovf[0] !== exp_ovf[i]) begin
                n_fail++;
                $display("FAIL up_wrap q/ovf step %0d: got q=%0d ovf=%b, required q=%0d ovf=%b",
                         i, dq[0], dovf[0], exp_q[i], exp_ovf[i]);
            end
        end
    endtask

    task automatic test_down_saturate();
        logic [3:0] exp_q   [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        set_in(1'b0, 2'b00, 4'd0, 1'b1, 4'd2, 1'b1);
        cycle();
        set_in(1'b1, 2'b11, 4'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (dtc[1] !== exp_tc[i]) begin
                n_fail++;
                $display("FAIL down_sat tc step %0d: got %b, required %b", i, dtc[1], exp_tc[i]);
            end
            cycle();
            n_checks++;
            if (dq[1] !== exp_q[i] || dovf[1] !== exp_ovf[i]) begin
                n_fail++;
                $display("FAIL down_sat q/ovf step %0d: got q=%0d ovf=%b, required q=%0d ovf=%b",
                         i, dq[1], dovf[1], exp_q[i], exp_ovf[i]);
            end
        end
    endtask

    task automatic test_toggle();
        logic [3:0] tv    [2] = '{4'b1010, 4'b0110};
        logic [3:0] exp_q [2] = '{4'b1010, 4'b1100};
        set_in(1'b0, 2'b00, 4'd0, 1'b1, 4'd0, 1'b0);
        cycle();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 2'b01, tv[i], 1'b0, 4'd0, 1'b0);
            #1;
            n_checks++;
            if (dtc[0] !== 1'b0 || dtc[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL toggle tc step %0d: got %b/%b, required 0", i, dtc[0], dtc[1]);
            end
            cycle();
            n_checks++;
            if (dq[0] !== exp_q[i] || dq[1] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL toggle q step %0d: got %b/%b, required %b", i, dq[0], dq[1], exp_q[i]);
            end
        end
    endtask

    task automatic test_priority();
        set_in(1'b0, 2'b00, 4'd0, 1'b1, 4'd15, 1'b0);
        cycle();
        set_in(1'b1, 2'b10, 4'd0, 1'b1, 4'd7, 1'b0);
        #1;
        n_checks++;
        if (dtc[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL priority load tc: got %b, required 0", dtc[0]);
        end
        cycle();
        n_checks++;
        if (dq[0] !== 4'd7 || dovf[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL priority load: got q=%0d ovf=%b, required q=7 ovf=1", dq[0], dovf[0]);
        end
        set_in(1'b0, 2'b10, 4'd0, 1'b0, 4'd0, 1'b0);
        cycle();
        n_checks++;
        if (dq[0] !== 4'd7 || dtc[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL priority en_low: got q=%0d tc=%b, required q=7 tc=0", dq[0], dtc[0]);
        end
    endtask

    task automatic test_ovf_race();
        set_in(1'b0, 2'b00, 4'd0, 1'b1, 4'd15, 1'b1);
        cycle();
        n_checks++;
        if (dovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_race pre-clear: got ovf=%b, required 0", dovf[0]);
        end
        set_in(1'b1, 2'b10, 4'd0, 1'b0, 4'd0, 1'b1);
        cycle();
        n_checks++;
        if (dovf[0] !== 1'b1 || dq[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL ovf_race set_wins: got ovf=%b q=%0d, required ovf=1 q=0", dovf[0], dq[0]);
        end
        cycle();
        n_checks++;
        if (dovf[0] !== 1'b0 || dq[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL ovf_race clear: got ovf=%b q=%0d, required ovf=0 q=1", dovf[0], dq[0]);
        end
    endtask

    task automatic test_async_reset();
        set_in(1'b0, 2'b00, 4'd0, 1'b1, 4'd9, 1'b0);
        cycle();
        set_in(1'b1, 2'b10, 4'd0, 1'b1, 4'd15, 1'b0);
        cycle();
        set_in(1'b1, 2'b10, 4'd0, 1'b0, 4'd0, 1'b0);
        cycle();
        set_in(1'b0, 2'b00, 4'd0, 1'b1, 4'd9, 1'b0);
        cycle();
        n_checks++;
        if (dq[0] !== 4'd9 || dovf[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset setup: got q=%0d ovf=%b, required q=9 ovf=1", dq[0], dovf[0]);
        end
        set_in(1'b0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dq[k] !== 4'(rv_of(k)) || dovf[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got q=%0d ovf=%b, required q=%0d ovf=0",
                         k, dq[k], dovf[k], rv_of(k));
            end
        end
        #1;
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom),
                   1'($urandom_range(0, 9) == 0), 4'($urandom), 1'($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 3) == 0) begin
                d = (mode == 2'b11) ? 4'd0 : 4'd15;
                load = 1'b1;
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (dtc[k] !== model_tc(mq[k])) begin
                    n_fail++;
                    $display("FAIL random tc dut%0d iter %0d: got %b, required %b",
                             k, i, dtc[k], model_tc(mq[k]));
                end
            end
            cycle();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (dq[k] !== mq[k] || dovf[k] !== movf[k]) begin
                    n_fail++;
                    $display("FAIL random q/ovf dut%0d iter %0d: got q=%0d ovf=%b, required q=%0d ovf=%b",
                             k, i, dq[k], dovf[k], mq[k], movf[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_saturate();
        test_toggle();
        test_priority();
        test_ovf_race();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
